mmio_out_fifo: RTL and testbench

- Downstream consumer of the multi-cycle CPU's memory-write bus (memWr / adr / writedata).
- Captures writes to a memory-mapped output address into a small FIFO and drains it to an external sink over a valid/ready handshake.
- Exposes a readable status byte and a last-written OUT mirror, so the CPU core and bench can observe port activity.

---
 rtl/mmio_out_fifo_pkg.sv | 29 ++
 rtl/mmio_out_fifo_if.sv | 26 ++
 rtl/mmio_out_fifo_sync_fifo.sv | 72 +++++++
 rtl/mmio_out_fifo.sv | 80 ++++++++
 tb/tb_mmio_out_fifo.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mmio_out_fifo_pkg.sv
// Shared constants for the MMIO output port: default decode addresses, status byte layout and a
// helper that packs the status byte so every consumer agrees on bit positions.
package mmio_out_fifo_pkg;

  localparam logic [7:0] OutAddrDefault    = 8'hFF;
  localparam logic [7:0] StatusAddrDefault = 8'hFE;

  localparam int unsigned DataW  = 8;
  localparam int unsigned LevelW = 4;

  // Status byte bit positions.
  localparam int unsigned StOvfBit   = 7;
  localparam int unsigned StFullBit  = 6;
  localparam int unsigned StEmptyBit = 5;
  localparam int unsigned StLevelMsb = 3;
  localparam int unsigned StLevelLsb = 0;

  function automatic logic [7:0] status_byte(input logic ovf, input logic full,
                                             input logic empty, input logic [LevelW-1:0] lvl);
    logic [7:0] s;
    s = '0;
    s[StOvfBit]                 = ovf;
    s[StFullBit]                = full;
    s[StEmptyBit]               = empty;
    s[StLevelMsb:StLevelLsb]    = lvl;
    return s;
  endfunction

endpackage

// File: rtl/mmio_out_fifo_if.sv
// Bus bundle for mmio_out_fifo.
//   CPU side : memWr, adr, writedata (driven by CPU), rd_data (combinational read-back)
//   Sink side: out_data, out_valid (from FIFO), out_ready (from sink)
// master = CPU/sink side, slave = the FIFO block.
interface mmio_out_fifo_if;
  import mmio_out_fifo_pkg::*;

  logic             memWr;
  logic [7:0]       adr;
  logic [DataW-1:0] writedata;
  logic [DataW-1:0] rd_data;
  logic [DataW-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output memWr, adr, writedata, out_ready,
    input  rd_data, out_data, out_valid
  );

  modport slave (
    input  memWr, adr, writedata, out_ready,
    output rd_data, out_data, out_valid
  );

endinterface

// File: rtl/mmio_out_fifo_sync_fifo.sv
// Depth x 8 synchronous FIFO with separately tracked occupancy.
//   clk_i, rst_ni : clock, async active-low reset
//   push_i/wdata_i: write request and data (ignored when full unless a pop coincides)
//   pop_i         : read request (ignored when empty)
//   rdata_o       : head entry, forced to 0 while empty
//   valid_o/full_o/level_o : occupancy status from the registered level
module mmio_out_fifo_sync_fifo
  import mmio_out_fifo_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DataW-1:0]  wdata_i,
  input  logic              pop_i,
  output logic [DataW-1:0]  rdata_o,
  output logic              valid_o,
  output logic              full_o,
  output logic [LevelW-1:0] level_o
);

  localparam int unsigned    PtrW     = $clog2(Depth);
  localparam logic [LevelW-1:0] DepthLvl = LevelW'(Depth);

  logic [DataW-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic              push_ok, pop_ok;

  assign valid_o = (level_q != '0);
  assign full_o  = (level_q == DepthLvl);
  assign level_o = level_q;
  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;

  assign pop_ok  = pop_i && valid_o;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Pointers are exactly log2(Depth) bits, so the increment wraps on its own.
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; rdata_o is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mmio_out_fifo.sv
// Memory-mapped output port: CPU stores to OUT_ADDR are queued and drained to a sink over
// valid/ready; STATUS_ADDR reads the status byte and a store there clears the overflow flag.
//   clk, reset : clock, async active-low reset
//   bus        : CPU write bus, combinational rd_data, sink handshake (slave modport)
//   OUT        : last value accepted into the FIFO
//   full       : occupancy == DEPTH
//   overflow   : sticky, a push was dropped
//   level      : current occupancy
module mmio_out_fifo
  import mmio_out_fifo_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter logic [7:0]  OUT_ADDR    = OutAddrDefault,
  parameter logic [7:0]  STATUS_ADDR = StatusAddrDefault
) (
  input  logic              clk,
  input  logic              reset,
  mmio_out_fifo_if.slave    bus,
  output logic [DataW-1:0]  OUT,
  output logic              full,
  output logic              overflow,
  output logic [LevelW-1:0] level
);

  logic             push_req, clr_req, pop, push_ok, drop;
  logic [DataW-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;

  assign push_req = bus.memWr && (bus.adr == OUT_ADDR);
  assign clr_req  = bus.memWr && (bus.adr == STATUS_ADDR);
  assign pop      = bus.out_valid && bus.out_ready;
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  mmio_out_fifo_sync_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push_ok),
    .wdata_i (bus.writedata),
    .pop_i   (pop),
    .rdata_o (bus.out_data),
    .valid_o (bus.out_valid),
    .full_o  (full),
    .level_o (level)
  );

  always_comb begin
    out_d = out_q;
    ovf_d = ovf_q;
    if (push_ok) out_d = bus.writedata;
    // Clear has priority over a dropped push on the same edge.
    if (clr_req)   ovf_d = 1'b0;
    else if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign OUT      = out_q;
  assign overflow = ovf_q;

  always_comb begin
    bus.rd_data = '0;
    if (bus.adr == STATUS_ADDR) begin
      bus.rd_data = status_byte(ovf_q, full, !bus.out_valid, level);
    end else if (bus.adr == OUT_ADDR) begin
      bus.rd_data = out_q;
    end
  end

endmodule

// File: tb/tb_mmio_out_fifo.sv
// Scoreboard bench for mmio_out_fifo: accepted pushes queue their data, a negedge monitor
// compares each sink transfer against the queue head; directed checks cover status and flags.
module tb_mmio_out_fifo;
  import mmio_out_fifo_pkg::*;

  localparam int unsigned Depth = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] out_mirror;
  logic       full, overflow;
  logic [3:0] level;

  mmio_out_fifo_if bus ();

  mmio_out_fifo #(
    .DEPTH (Depth)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .bus      (bus),
    .OUT      (out_mirror),
    .full     (full),
    .overflow (overflow),
    .level    (level)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic [7:0] m_out;
  logic       m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // A transfer is visible at the negedge preceding the edge that performs it.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sink_unexpected got %02h want none", bus.out_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (bus.out_data !== mon_exp) begin
            failures++;
            $display("FAIL sink_data got %02h want %02h", bus.out_data, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // Store one byte; the model decides acceptance from queue occupancy and this cycle's ready.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    logic pop;
    pop = (exp_q.size() != 0) && bus.out_ready;
    bus.memWr     = 1'b1;
    bus.adr       = a;
    bus.writedata = d;
    if (a == 8'hFF) begin
      if (exp_q.size() < Depth || pop) begin
        exp_q.push_back(d);
        m_out = d;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (a == 8'hFE) begin
      m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    bus.memWr = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    bus.adr = a;
    #1;
    chk(name, bus.rd_data, exp);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    bus.adr       = 8'h00;
    for (int i = 0; i < 20 && level != 0; i++) idle();
    chk("drain_level", level, 0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.memWr     = 1'b0;
    bus.adr       = 8'hFE;
    bus.writedata = 8'h00;
    bus.out_ready = 1'b0;
    m_out         = 8'h00;
    m_ovf         = 1'b0;
    rst_n         = 1'b0;

    // Reset and idle
    #3;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_out", out_mirror, 0);
    chk("rst_level", level, 0);
    #9;
    rst_n = 1'b1;
    idle();
    chk("idle_full", full, 0);
    chk("idle_ovf", overflow, 0);
    rd_chk("idle_status", 8'hFE, 8'h20);

    // Single store, held with ready low, then one-cycle pop
    wr(8'hFF, 8'h5A);
    chk("s1_valid", bus.out_valid, 1);
    chk("s1_data", bus.out_data, 8'h5A);
    chk("s1_out", out_mirror, m_out);
    chk("s1_level", level, 1);
    idle();
    chk("s1_hold_valid", bus.out_valid, 1);
    chk("s1_hold_data", bus.out_data, 8'h5A);
    bus.out_ready = 1'b1;
    idle();
    bus.out_ready = 1'b0;
    chk("s1_pop_valid", bus.out_valid, 0);
    chk("s1_pop_level", level, 0);

    // Fill, overflow, drain, clear
    for (int i = 1; i <= 4; i++) wr(8'hFF, 8'(i));
    chk("fill_full", full, 1);
    chk("fill_level", level, 4);
    rd_chk("fill_status", 8'hFE, 8'h44);
    wr(8'hFF, 8'h05);
    chk("ovf_flag", overflow, m_ovf);
    chk("ovf_level", level, 4);
    rd_chk("ovf_status", 8'hFE, 8'hC4);
    rd_chk("ovf_out_rd", 8'hFF, 8'h04);
    chk("ovf_out", out_mirror, m_out);
    rd_chk("other_addr", 8'h10, 8'h00);
    drain();
    chk("drain_ovf_sticky", overflow, 1);
    wr(8'hFE, 8'h77);
    chk("ovf_clear", overflow, m_ovf);
    rd_chk("clear_status", 8'hFE, 8'h20);

    // Full FIFO with simultaneous push and pop
    for (int i = 1; i <= 4; i++) wr(8'hFF, 8'(i));
    bus.out_ready = 1'b1;
    wr(8'hFF, 8'hAA);
    chk("pp_level", level, 4);
    chk("pp_full", full, 1);
    chk("pp_ovf", overflow, 0);
    chk("pp_out", out_mirror, 8'hAA);
    drain();

    // Interleaved pushes and pops across pointer wraps
    for (int i = 0; i < 10; i++) begin
      bus.out_ready = (i % 3 != 0);
      wr(8'hFF, 8'h30 + 8'(i));
      chk("wrap_lvl_bound", level <= 4, 1);
    end
    chk("wrap_ovf", overflow, m_ovf);
    chk("wrap_out", out_mirror, 8'h39);
    drain();

    // Asynchronous reset mid-drain
    for (int i = 0; i < 3; i++) wr(8'hFF, 8'h11 * 8'(i + 1));
    bus.out_ready = 1'b1;
    idle();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    bus.out_ready = 1'b0;
    m_out = 8'h00;
    m_ovf = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_out", out_mirror, 0);
    chk("arst_data", bus.out_data, 0);
    #3;
    rst_n = 1'b1;
    idle();
    wr(8'hFF, 8'h5A);
    chk("post_valid", bus.out_valid, 1);
    chk("post_data", bus.out_data, 8'h5A);
    chk("post_level", level, 1);
    chk("post_out", out_mirror, m_out);
    drain();

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
